// File: rtl/onfi_dummy_dut.sv
// Behavioural single-LUN ONFI SDR NAND target: decodes CLE/ALE/WE/RE pin cycles
// into reset, status, ID, page read, program and erase against a small page array.
module onfi_dummy_dut #(
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 8,
  parameter int T_RST      = 8,
  parameter int T_R        = 16,
  parameter int T_PROG     = 32,
  parameter int T_BERS     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CE_x_n,
  input  logic       CLE_x,
  input  logic       ALE_x,
  input  logic       WE_x_n,
  input  logic       RE_x_n,
  input  logic       WP_x_n,
  inout  wire        DQ0_0,
  inout  wire        IO1_0,
  inout  wire        IO2_0,
  inout  wire        IO3_0,
  inout  wire        IO4_0,
  inout  wire        IO5_0,
  inout  wire        IO6_0,
  inout  wire        IO7_0,
  input  logic [7:0] IO_bus,
  output logic       RB_x_n,
  input  logic       Vcc, VccQ, Vss, VssQ, VREFQ_x, Vpp, ZQ_x, R, RFT, NU, NC, VSP_x,
  input  logic       RE_x_c, WR_x_n, CLK_x, IOS, IOS_x_c, DBI_x, ENo, ENi,
  input  logic       IO8, IO9, IO10, IO11, IO12, IO13, IO14, IO15,
  input  logic       IO0_1, IO1_1, IO2_1, IO3_1, IO4_1, IO5_1, IO6_1, IO7_1
);
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int RW = $clog2(NUM_PAGES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT_CONF, S_DATA_IN, S_BUSY, S_DATA_OUT, S_ID_OUT, S_STATUS_OUT
  } state_t;
  typedef enum logic [2:0] {OP_NONE, OP_RST, OP_READ, OP_PROG, OP_ERASE, OP_ID} op_t;

  state_t state;
  op_t    op;
  logic   we_n_p0, re_n_p0;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    addr_idx;
  logic [7:0]    id_addr;
  logic [2:0]    id_ptr;
  logic [15:0]   busy_cnt;
  logic          fail, wp_blk, stat_rd;
  logic [NUM_PAGES-1:0][PAGE_BYTES-1:0][7:0] mem;
  logic [PAGE_BYTES-1:0][7:0]                page_reg;

  logic we_rise, re_rise, is_cmd, is_addr, is_data, stat_req, drive;
  logic [7:0] dout;
  logic unused_pins;

  function automatic logic [7:0] status_byte(input logic wp, input logic rdy, input logic f);
    return {wp, rdy, rdy, 4'b0000, f};
  endfunction

  function automatic logic [7:0] id_byte(input logic [7:0] a, input logic [2:0] p);
    logic [7:0] b;
    b = 8'h00;
    if (a == 8'h00) begin
      case (p)
        3'd0: b = 8'h2C;
        3'd1: b = 8'hDA;
        3'd2: b = 8'h90;
        3'd3: b = 8'h95;
        default: b = 8'h00;
      endcase
    end else if (a == 8'h20) begin
      case (p)
        3'd0: b = 8'h4F;
        3'd1: b = 8'h4E;
        3'd2: b = 8'h46;
        3'd3: b = 8'h49;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Edges are found against the previous-cycle pin value; chip enable gates every cycle type.
  assign we_rise  = !we_n_p0 && WE_x_n && !CE_x_n;
  assign re_rise  = !re_n_p0 && RE_x_n && !CE_x_n;
  assign is_cmd   = CLE_x && !ALE_x;
  assign is_addr  = ALE_x && !CLE_x;
  assign is_data  = !ALE_x && !CLE_x;
  assign stat_req = stat_rd || (we_rise && is_cmd && IO_bus == 8'h70);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op       <= OP_NONE;
      we_n_p0  <= 1'b1;
      re_n_p0  <= 1'b1;
      col      <= '0;
      row      <= '0;
      addr_idx <= '0;
      id_addr  <= '0;
      id_ptr   <= '0;
      busy_cnt <= '0;
      fail     <= 1'b0;
      wp_blk   <= 1'b0;
      stat_rd  <= 1'b0;
      mem      <= '1;
      page_reg <= '1;
    end else begin
      we_n_p0 <= WE_x_n;
      re_n_p0 <= RE_x_n;
      if (state == S_BUSY) begin
        stat_rd <= stat_req;
        if (busy_cnt == '0) begin
          // Array commit coincides with the ready edge.
          case (op)
            OP_READ:  page_reg <= mem[row];
            OP_PROG:  if (!wp_blk) mem[row] <= mem[row] & page_reg;
            OP_ERASE: if (!wp_blk) begin
              mem[{row[RW-1:1], 1'b0}] <= '1;
              mem[{row[RW-1:1], 1'b1}] <= '1;
            end
            OP_RST:   fail <= 1'b0;
            default:  ;
          endcase
          stat_rd <= 1'b0;
          if (stat_req)           state <= S_STATUS_OUT;
          else if (op == OP_READ) state <= S_DATA_OUT;
          else                    state <= S_IDLE;
        end else begin
          busy_cnt <= busy_cnt - 16'd1;
        end
      end else if (we_rise && is_cmd) begin
        addr_idx <= '0;
        stat_rd  <= 1'b0;
        case (IO_bus)
          8'hFF: begin state <= S_BUSY; op <= OP_RST; busy_cnt <= 16'(T_RST - 1); end
          8'h70: state <= S_STATUS_OUT;
          8'h90: begin state <= S_ADDR; op <= OP_ID; end
          8'h00: begin state <= S_ADDR; op <= OP_READ; end
          8'h80: begin state <= S_ADDR; op <= OP_PROG; page_reg <= '1; end
          8'h60: begin state <= S_ADDR; op <= OP_ERASE; end
          8'h30:
            if (state == S_WAIT_CONF && op == OP_READ) begin
              state <= S_BUSY; busy_cnt <= 16'(T_R - 1);
            end else state <= S_IDLE;
          8'h10:
            if (state == S_DATA_IN && op == OP_PROG) begin
              state <= S_BUSY; busy_cnt <= 16'(T_PROG - 1);
              fail <= !WP_x_n; wp_blk <= !WP_x_n;
            end else state <= S_IDLE;
          8'hD0:
            if (state == S_WAIT_CONF && op == OP_ERASE) begin
              state <= S_BUSY; busy_cnt <= 16'(T_BERS - 1);
              fail <= !WP_x_n; wp_blk <= !WP_x_n;
            end else state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end else if (we_rise && is_addr && state == S_ADDR) begin
        addr_idx <= addr_idx + 3'd1;
        case (op)
          OP_ID: begin id_addr <= IO_bus; id_ptr <= '0; state <= S_ID_OUT; end
          OP_ERASE: begin
            if (addr_idx == 3'd0) row <= IO_bus[RW-1:0];
            if (addr_idx == 3'd2) state <= S_WAIT_CONF;
          end
          default: begin
            if (addr_idx == 3'd0) col <= IO_bus[CW-1:0];
            if (addr_idx == 3'd2) row <= IO_bus[RW-1:0];
            if (addr_idx == 3'd4) state <= (op == OP_PROG) ? S_DATA_IN : S_WAIT_CONF;
          end
        endcase
      end else if (we_rise && is_data && state == S_DATA_IN) begin
        page_reg[col] <= IO_bus;
        col           <= col + 1'b1;
      end else if (re_rise) begin
        if (state == S_DATA_OUT) col <= col + 1'b1;
        if (state == S_ID_OUT && id_ptr != 3'd4) id_ptr <= id_ptr + 3'd1;
      end
    end
  end

  always_comb begin
    dout = 8'h00;
    case (state)
      S_DATA_OUT:           dout = page_reg[col];
      S_ID_OUT:             dout = id_byte(id_addr, id_ptr);
      S_STATUS_OUT, S_BUSY: dout = status_byte(WP_x_n, state != S_BUSY, fail);
      default:              dout = 8'h00;
    endcase
  end

  assign drive  = !CE_x_n && !RE_x_n &&
                  (state == S_DATA_OUT || state == S_ID_OUT || state == S_STATUS_OUT ||
                   (state == S_BUSY && stat_rd));
  assign RB_x_n = (state != S_BUSY);

  assign DQ0_0 = drive ? dout[7] : 1'bz;
  assign IO1_0 = drive ? dout[6] : 1'bz;
  assign IO2_0 = drive ? dout[5] : 1'bz;
  assign IO3_0 = drive ? dout[4] : 1'bz;
  assign IO4_0 = drive ? dout[3] : 1'bz;
  assign IO5_0 = drive ? dout[2] : 1'bz;
  assign IO6_0 = drive ? dout[1] : 1'bz;
  assign IO7_0 = drive ? dout[0] : 1'bz;

  assign unused_pins = ^{Vcc, VccQ, Vss, VssQ, VREFQ_x, Vpp, ZQ_x, R, RFT, NU, NC, VSP_x,
                         RE_x_c, WR_x_n, CLK_x, IOS, IOS_x_c, DBI_x, ENo, ENi,
                         IO8, IO9, IO10, IO11, IO12, IO13, IO14, IO15,
                         IO0_1, IO1_1, IO2_1, IO3_1, IO4_1, IO5_1, IO6_1, IO7_1};
endmodule

// File: tb/tb_onfi_dummy_dut.sv
// Bench for onfi_dummy_dut: directed protocol sequences plus randomized operations
// checked against a page-array reference model.
module tb_onfi_dummy_dut;
  localparam int PB = 16;
  localparam int NP = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic CE_x_n = 1'b1, CLE_x = 1'b0, ALE_x = 1'b0, WE_x_n = 1'b1, RE_x_n = 1'b1, WP_x_n = 1'b1;
  logic [7:0] IO_bus = 8'h00;
  logic ign = 1'b0;
  wire DQ0_0, IO1_0, IO2_0, IO3_0, IO4_0, IO5_0, IO6_0, IO7_0;
  wire RB_x_n;
  wire [7:0] bus = {DQ0_0, IO1_0, IO2_0, IO3_0, IO4_0, IO5_0, IO6_0, IO7_0};

  int n_checks = 0, n_errs = 0, busy_total = 0;
  logic [7:0] mem_m [NP][PB];
  logic fail_m = 1'b0;

  onfi_dummy_dut dut (
    .clk(clk), .rst(rst), .CE_x_n(CE_x_n), .CLE_x(CLE_x), .ALE_x(ALE_x), .WE_x_n(WE_x_n),
    .RE_x_n(RE_x_n), .WP_x_n(WP_x_n),
    .DQ0_0(DQ0_0), .IO1_0(IO1_0), .IO2_0(IO2_0), .IO3_0(IO3_0), .IO4_0(IO4_0),
    .IO5_0(IO5_0), .IO6_0(IO6_0), .IO7_0(IO7_0),
    .IO_bus(IO_bus), .RB_x_n(RB_x_n),
    .Vcc(ign), .VccQ(ign), .Vss(ign), .VssQ(ign), .VREFQ_x(ign), .Vpp(ign), .ZQ_x(ign),
    .R(ign), .RFT(ign), .NU(ign), .NC(ign), .VSP_x(ign),
    .RE_x_c(ign), .WR_x_n(ign), .CLK_x(ign), .IOS(ign), .IOS_x_c(ign), .DBI_x(ign),
    .ENo(ign), .ENi(ign),
    .IO8(ign), .IO9(ign), .IO10(ign), .IO11(ign), .IO12(ign), .IO13(ign), .IO14(ign), .IO15(ign),
    .IO0_1(ign), .IO1_1(ign), .IO2_1(ign), .IO3_1(ign), .IO4_1(ign), .IO5_1(ign),
    .IO6_1(ign), .IO7_1(ign)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (RB_x_n === 1'b0) busy_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: status rules, ID tables, program (AND of FF-filled page) and erase.
  function automatic logic [7:0] status_m(input logic rdy);
    return {WP_x_n, rdy, rdy, 4'b0000, fail_m};
  endfunction

  function automatic logic [7:0] id_m(input logic [7:0] a, input int i);
    logic [7:0] t00 [4] = '{8'h2C, 8'hDA, 8'h90, 8'h95};
    logic [7:0] t20 [4] = '{8'h4F, 8'h4E, 8'h46, 8'h49};
    if (i >= 4) return 8'h00;
    if (a == 8'h00) return t00[i];
    if (a == 8'h20) return t20[i];
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < NP; p++) for (int c = 0; c < PB; c++) mem_m[p][c] = 8'hFF;
    fail_m = 1'b0;
  endtask

  task automatic latch(input logic cle, input logic ale, input logic [7:0] b);
    @(negedge clk); CLE_x = cle; ALE_x = ale; IO_bus = b; WE_x_n = 1'b0;
    @(negedge clk); WE_x_n = 1'b1;
    @(negedge clk);
    @(negedge clk); CLE_x = 1'b0; ALE_x = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c); latch(1'b1, 1'b0, c); endtask
  task automatic adr(input logic [7:0] a); latch(1'b0, 1'b1, a); endtask
  task automatic din(input logic [7:0] d); latch(1'b0, 1'b0, d); endtask

  task automatic addr5(input int c, input int r);
    adr(8'(c)); adr(8'h00); adr(8'(r)); adr(8'h00); adr(8'h00);
  endtask

  task automatic rd(output logic [7:0] b);
    @(negedge clk); RE_x_n = 1'b0;
    @(negedge clk); b = bus; RE_x_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (RB_x_n !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    chk(tag, 32'(RB_x_n), 32'd1);
  endtask

  task automatic confirm(input logic [7:0] c, input int t, input string tag);
    int start;
    start = busy_total;
    cmd(c);
    wait_ready({tag, "_ready"});
    chk({tag, "_busy_len"}, 32'(busy_total - start), 32'(t));
  endtask

  task automatic do_prog(input int r, input int c, input int n, input logic [7:0] d [4],
                         input logic wp);
    logic [7:0] pr [PB];
    cmd(8'h80); addr5(c, r);
    for (int i = 0; i < n; i++) din(d[i]);
    WP_x_n = wp;
    confirm(8'h10, 32, "prog");
    for (int i = 0; i < PB; i++) pr[i] = 8'hFF;
    for (int i = 0; i < n; i++) pr[(c + i) % PB] = d[i];
    if (wp) for (int i = 0; i < PB; i++) mem_m[r][i] &= pr[i];
    fail_m = !wp;
  endtask

  task automatic do_erase(input int r, input logic wp);
    cmd(8'h60); adr(8'(r)); adr(8'h00); adr(8'h00);
    WP_x_n = wp;
    confirm(8'hD0, 64, "erase");
    if (wp) for (int i = 0; i < PB; i++) begin
      mem_m[r & ~1][i] = 8'hFF;
      mem_m[r | 1][i]  = 8'hFF;
    end
    fail_m = !wp;
  endtask

  task automatic do_read(input int r, input int c, input int n, input string tag);
    logic [7:0] b;
    cmd(8'h00); addr5(c, r);
    confirm(8'h30, 16, "read");
    for (int i = 0; i < n; i++) begin
      rd(b);
      chk(tag, b, mem_m[r][(c + i) % PB]);
    end
  endtask

  task automatic do_status(input string tag);
    logic [7:0] b;
    cmd(8'h70); rd(b); chk(tag, b, status_m(1'b1));
  endtask

  task automatic do_id(input logic [7:0] a, input int n);
    logic [7:0] b;
    cmd(8'h90); adr(a);
    for (int i = 0; i < n; i++) begin rd(b); chk("id", b, id_m(a, i)); end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d [4];
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0; CE_x_n = 1'b0;
    @(negedge clk);
    chk("rb_after_reset", 32'(RB_x_n), 32'd1);
    do_status("status_reset");
    do_id(8'h20, 5);
    do_id(8'h00, 4);

    d = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    do_prog(3, 5, 2, d, 1'b1);
    do_read(3, 5, 3, "prog_readback");
    do_erase(3, 1'b1);
    do_read(2, 0, PB, "erase_p2");
    do_read(3, 0, PB, "erase_p3");

    d = '{8'h00, 8'h11, 8'h00, 8'h00};
    do_prog(1, 0, 2, d, 1'b0);
    do_status("status_wp");
    WP_x_n = 1'b1;
    do_read(1, 0, PB, "wp_page_kept");

    d = '{8'h77, 8'h88, 8'h00, 8'h00};
    do_prog(4, 15, 2, d, 1'b1);
    do_read(4, 15, 2, "col_wrap");

    // Status polling while a program is still busy, then ready after it completes.
    cmd(8'h80); addr5(0, 6); din(8'h12); din(8'h34);
    cmd(8'h10);
    for (int i = 0; i < PB; i++) mem_m[6][i] &= (i == 0) ? 8'h12 : (i == 1) ? 8'h34 : 8'hFF;
    fail_m = 1'b0;
    cmd(8'h70); rd(b); chk("status_busy", b, status_m(1'b0));
    wait_ready("busy_status_ready");
    rd(b); chk("status_after_busy", b, status_m(1'b1));

    // An RE pulse with the chip deselected must not move the read pointer.
    cmd(8'h00); addr5(0, 6); confirm(8'h30, 16, "read_ce");
    rd(b); chk("ce_pause_b0", b, mem_m[6][0]);
    CE_x_n = 1'b1; rd(b); CE_x_n = 1'b0;
    rd(b); chk("ce_pause_b1", b, mem_m[6][1]);

    confirm(8'hFF, 8, "reset_cmd");
    fail_m = 1'b0;
    do_status("status_after_ff");

    for (int it = 0; it < 30; it++) begin
      int r, c, n;
      r = $urandom_range(0, NP - 1);
      c = $urandom_range(0, PB - 1);
      n = $urandom_range(1, 4);
      case ($urandom_range(0, 4))
        0: begin
          for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
          do_prog(r, c, n, d, $urandom_range(0, 3) != 0);
          do_status("rand_status_prog");
          WP_x_n = 1'b1;
        end
        1: begin
          do_erase(r, $urandom_range(0, 3) != 0);
          do_status("rand_status_erase");
          WP_x_n = 1'b1;
        end
        2: do_read(r, c, n, "rand_read");
        3: do_status("rand_status");
        default: do_id(($urandom_range(0, 2) == 0) ? 8'h00 :
                       ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h55, 5);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
